uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_bit_timer.sv | 31 +++
 rtl/uart_rx.sv | 219 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver slice.
// UART_RX_PARITY_EN adds the PARITY state to the receiver state enum.
package uart_pkg;

    localparam int unsigned DATA_W           = 8;
    localparam int unsigned DEF_CLKS_PER_BIT = 434;

    typedef logic [DATA_W-1:0] rx_byte_t;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;
`endif

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte handshake plus error strobes between uart_rx and its consumer.
// UART_RX_PARITY_EN adds the perr strobe.
interface uart_rx_if;
    import uart_pkg::*;

    rx_byte_t data;
    logic     valid;
    logic     ready;
    logic     ferr;
    logic     overrun;
`ifdef UART_RX_PARITY_EN
    logic     perr;

    modport master (output data, valid, ferr, overrun, perr, input ready);
    modport slave  (input data, valid, ferr, overrun, perr, output ready);
`else
    modport master (output data, valid, ferr, overrun, input ready);
    modport slave  (input data, valid, ferr, overrun, output ready);
`endif

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: wraps at CLKS_PER_BIT-1 and flags the half-bit and full-bit points.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned WIDTH        = 9
) (
    input  logic i_clk,
    input  logic i_srst,
    input  logic clear,
    output logic half_tick_c,
    output logic full_tick_c
);

    localparam logic [WIDTH-1:0] LAST      = WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [WIDTH-1:0] HALF_LAST = WIDTH'(CLKS_PER_BIT / 2 - 1);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_srst || clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    assign half_tick_c = (cnt == HALF_LAST);
    assign full_tick_c = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronized line, mid-bit sampling, 8 data bits LSB first, 1 stop bit.
// Define UART_RX_PARITY_EN to expect an even-parity bit after bit 7 and drive perr.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int unsigned WIDTH        = 9
) (
    input  logic      i_clk,
    input  logic      i_srst,
    input  logic      i_rx,
    uart_rx_if.master rx_bus
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

    rx_state_e state;
    rx_state_e state_nxt;

    logic     rx_meta;
    logic     rx_sync;
    logic     rx_prev;
    logic     half_tick_c;
    logic     full_tick_c;
    logic     timer_clr_c;
    logic     enter_data_c;
    logic     shift_en_c;
    logic     frame_ok_c;
    logic     ferr_c;
    logic     par_bad;
    logic [2:0] bit_cnt;
    rx_byte_t shift_q;
    rx_byte_t data_q;
    logic     valid_q;
    logic     ferr_q;
    logic     overrun_q;

`ifdef UART_RX_PARITY_EN
    logic perr_c;
    logic perr_q;
    logic par_bad_q;
`endif

    // two-flop line synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .WIDTH        (WIDTH)
    ) u_bit_timer (
        .i_clk       (i_clk),
        .i_srst      (i_srst),
        .clear       (timer_clr_c),
        .half_tick_c (half_tick_c),
        .full_tick_c (full_tick_c)
    );

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!rx_sync && rx_prev) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (half_tick_c) begin
                    state_nxt = rx_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (full_tick_c && (bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (full_tick_c) begin
                    state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (full_tick_c) begin
                    state_nxt = rx_sync ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rx_sync) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // timer is held cleared while waiting for an edge, so START always begins at count 0
    always_comb begin
        timer_clr_c  = 1'b0;
        enter_data_c = 1'b0;
        shift_en_c   = 1'b0;
        frame_ok_c   = 1'b0;
        ferr_c       = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_c       = 1'b0;
`endif
        case (state)
            ST_IDLE, ST_BREAK: begin
                timer_clr_c = 1'b1;
            end
            ST_START: begin
                if (half_tick_c) begin
                    timer_clr_c  = 1'b1;
                    enter_data_c = !rx_sync;
                end
            end
            ST_DATA: begin
                shift_en_c = full_tick_c;
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                perr_c = full_tick_c && (rx_sync != (^shift_q));
            end
`endif
            ST_STOP: begin
                if (full_tick_c) begin
                    frame_ok_c = rx_sync && !par_bad;
                    ferr_c     = !rx_sync;
                end
            end
            default: ;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    // a parity miss is remembered until the stop bit so the byte is dropped there
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
        end else begin
            perr_q <= perr_c;
            if (enter_data_c) begin
                par_bad_q <= 1'b0;
            end else if (perr_c) begin
                par_bad_q <= 1'b1;
            end
        end
    end

    assign par_bad     = par_bad_q;
    assign rx_bus.perr = perr_q;
`else
    assign par_bad = 1'b0;
`endif

    // shift register, output buffer and handshake
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            bit_cnt   <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            ferr_q    <= ferr_c;
            overrun_q <= 1'b0;
            if (enter_data_c) begin
                bit_cnt <= '0;
            end else if (shift_en_c) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (shift_en_c) begin
                shift_q <= {rx_sync, shift_q[DATA_W-1:1]};
            end
            if (valid_q && rx_bus.ready) begin
                valid_q <= 1'b0;
            end
            // a consume in the same cycle frees the buffer for the new byte
            if (frame_ok_c) begin
                if (valid_q && !rx_bus.ready) begin
                    overrun_q <= 1'b1;
                end else begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign rx_bus.data    = data_q;
    assign rx_bus.valid   = valid_q;
    assign rx_bus.ferr    = ferr_q;
    assign rx_bus.overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=16: frame-level model plus directed literal checks.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned CLKS = 16;
    localparam int unsigned HALF = CLKS / 2;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NS = 10;
`else
    localparam int unsigned NS = 9;
`endif

    logic i_clk  = 1'b0;
    logic i_srst = 1'b1;
    logic i_rx   = 1'b1;

    uart_rx_if bus ();

    uart_rx #(
        .CLKS_PER_BIT (CLKS),
        .WIDTH        (5)
    ) dut (
        .i_clk  (i_clk),
        .i_srst (i_srst),
        .i_rx   (i_rx),
        .rx_bus (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int unsigned edge_n;
        bit          is_stop;
        logic [7:0]  b;
        bit          stop_ok;
        bit          par_ok;
    } ev_t;

    ev_t         evq[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          ferr_seen = 0;
    int          ovr_seen = 0;
    int          perr_seen = 0;

    logic [7:0] m_data = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_perr = 1'b0;

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    // frame-level model: a frame starting after edge e is judged at a fixed edge after it
    initial begin
        ev_t  ev;
        logic old_valid;
        forever begin
            @(posedge i_clk);
            cyc++;
            if (i_srst) begin
                m_data = 8'h00; m_valid = 1'b0;
                m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
                evq.delete();
            end else begin
                old_valid = m_valid;
                m_ferr = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
                if (m_valid && bus.ready) m_valid = 1'b0;
                while (evq.size() > 0 && evq[0].edge_n == cyc) begin
                    ev = evq.pop_front();
                    if (!ev.is_stop) begin
                        m_perr = !ev.par_ok;
                    end else if (!ev.stop_ok) begin
                        m_ferr = 1'b1;
                    end else if (ev.par_ok) begin
                        if (old_valid && !bus.ready) begin
                            m_ovr = 1'b1;
                        end else begin
                            m_data  = ev.b;
                            m_valid = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge i_clk);
            if (cyc >= 1) begin
                chk("valid", {7'b0, bus.valid}, {7'b0, m_valid});
                chk("data", bus.data, m_data);
                chk("ferr", {7'b0, bus.ferr}, {7'b0, m_ferr});
                chk("overrun", {7'b0, bus.overrun}, {7'b0, m_ovr});
                if (bus.ferr === 1'b1) ferr_seen++;
                if (bus.overrun === 1'b1) ovr_seen++;
`ifdef UART_RX_PARITY_EN
                chk("perr", {7'b0, bus.perr}, {7'b0, m_perr});
                if (bus.perr === 1'b1) perr_seen++;
`endif
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach the end, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_cycles(input int unsigned n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input bit par,
                              input int unsigned extra_low);
        ev_t         ev;
        int unsigned e;
        @(posedge i_clk);
        #1;
        e = cyc;
`ifdef UART_RX_PARITY_EN
        ev.edge_n = e + 3 + HALF + 9 * CLKS;
        ev.is_stop = 1'b0; ev.b = b; ev.stop_ok = stop; ev.par_ok = (par == (^b));
        evq.push_back(ev);
`endif
        ev.edge_n = e + 3 + HALF + NS * CLKS;
        ev.is_stop = 1'b1; ev.b = b; ev.stop_ok = stop; ev.par_ok = (par == (^b));
        evq.push_back(ev);
        i_rx = 1'b0;
        wait_cycles(CLKS);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            wait_cycles(CLKS);
        end
`ifdef UART_RX_PARITY_EN
        i_rx = par;
        wait_cycles(CLKS);
`endif
        i_rx = stop;
        wait_cycles(CLKS);
        if (!stop) wait_cycles(extra_low);
        i_rx = 1'b1;
        wait_cycles(4);
    endtask

    task automatic consume();
        bus.ready = 1'b1;
        wait_cycles(1);
        bus.ready = 1'b0;
    endtask

    initial begin
        int unsigned cyc0;
        int unsigned done;
        int          base;

        bus.ready = 1'b0;
        i_srst = 1'b1;
        i_rx = 1'b1;
        wait_cycles(3);
        i_srst = 1'b0;
        chk("rst_valid", {7'b0, bus.valid}, 8'h00);
        chk("rst_data", bus.data, 8'h00);
        chk("rst_ferr", {7'b0, bus.ferr}, 8'h00);
        chk("rst_overrun", {7'b0, bus.overrun}, 8'h00);
        wait_cycles(5);

        // plain frame, held until consumed
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        chk("a5_data", bus.data, 8'hA5);
        chk("a5_valid", {7'b0, bus.valid}, 8'h01);
        wait_cycles(6);
        chk("a5_held", {7'b0, bus.valid}, 8'h01);
        consume();
        chk("a5_consumed", {7'b0, bus.valid}, 8'h00);

        // short low glitch is rejected at the start mid-point
        i_rx = 1'b0;
        wait_cycles(4);
        i_rx = 1'b1;
        wait_cycles(30);
        chk("glitch_valid", {7'b0, bus.valid}, 8'h00);
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        chk("5a_data", bus.data, 8'h5A);
        consume();

        // framing error followed by a long break
        base = ferr_seen;
        send_frame(8'h3C, 1'b0, 1'b0, 40);
        chk("ferr_count", 8'(ferr_seen - base), 8'd1);
        chk("ferr_valid", {7'b0, bus.valid}, 8'h00);
        send_frame(8'h01, 1'b1, 1'b1, 0);
        chk("01_data", bus.data, 8'h01);
        chk("01_valid", {7'b0, bus.valid}, 8'h01);
        consume();

        // overrun: second byte dropped while the first is unconsumed
        base = ovr_seen;
        send_frame(8'h11, 1'b1, 1'b0, 0);
        send_frame(8'h22, 1'b1, 1'b0, 0);
        chk("ovr_data", bus.data, 8'h11);
        chk("ovr_count", 8'(ovr_seen - base), 8'd1);
        consume();

        // consume in the completion cycle: new byte loads, no overrun
        send_frame(8'h11, 1'b1, 1'b0, 0);
        base = ovr_seen;
        cyc0 = cyc;
        done = cyc0 + 1 + 3 + HALF + NS * CLKS;
        fork
            send_frame(8'h22, 1'b1, 1'b0, 0);
            begin
                for (int k = 0; k < 400 && cyc < done - 1; k++) wait_cycles(1);
                chk("ready_align", {7'b0, cyc == done - 1}, 8'h01);
                bus.ready = 1'b1;
                wait_cycles(1);
                bus.ready = 1'b0;
            end
        join
        chk("same_cycle_data", bus.data, 8'h22);
        chk("same_cycle_valid", {7'b0, bus.valid}, 8'h01);
        chk("same_cycle_ovr", 8'(ovr_seen - base), 8'd0);
        consume();

        // reset in the middle of data bit 3
        fork
            send_frame(8'hFF, 1'b1, 1'b0, 0);
            begin
                wait_cycles(1 + 4 * CLKS + HALF);
                i_srst = 1'b1;
                wait_cycles(1);
                i_srst = 1'b0;
            end
        join
        chk("srst_valid", {7'b0, bus.valid}, 8'h00);
        chk("srst_data", bus.data, 8'h00);
        send_frame(8'h7E, 1'b1, 1'b0, 0);
        chk("7e_data", bus.data, 8'h7E);
        consume();

`ifdef UART_RX_PARITY_EN
        base = perr_seen;
        send_frame(8'h07, 1'b1, 1'b0, 0);
        chk("perr_count", 8'(perr_seen - base), 8'd1);
        chk("perr_valid", {7'b0, bus.valid}, 8'h00);
        send_frame(8'h07, 1'b1, 1'b1, 0);
        chk("par_ok_data", bus.data, 8'h07);
        chk("par_ok_valid", {7'b0, bus.valid}, 8'h01);
        consume();
`endif

        wait_cycles(5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
